// File: rtl/sine_meas.sv
// Periodic sample-stream monitor: finds rising midpoint crossings with hysteresis and
// publishes period, peak max/min and peak-to-peak amplitude once per waveform cycle.
module sine_meas #(
    parameter int DATA_W   = 10,
    parameter int MID      = 511,
    parameter int HYST     = 16,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_sample,
    output logic                meas_valid,
    output logic [PERIOD_W-1:0] period,
    output logic [DATA_W-1:0]   peak_max,
    output logic [DATA_W-1:0]   peak_min,
    output logic [DATA_W-1:0]   amplitude,
    output logic                locked,
    output logic                timeout_err
);

    // A negative arm threshold is legal; arming then simply never happens.
    localparam int                  ARM_TH   = MID - HYST;
    localparam bit                  ARM_EN   = (ARM_TH > 0);
    localparam logic [DATA_W:0]     ARM_TH_W = ARM_TH[DATA_W:0];
    localparam logic [DATA_W-1:0]   MID_W    = MID[DATA_W-1:0];
    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
    localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    if (MID + HYST > (1 << DATA_W) - 1) begin : g_bad_cfg
        $error("sine_meas: MID+HYST exceeds the sample range");
    end

    typedef enum logic {SEEK, MEASURE} state_t;

    state_t                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]     min_q, min_d, max_q, max_d;
    logic                  mv_q, mv_d, to_q, to_d, locked_q, locked_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [DATA_W-1:0]     pmax_q, pmax_d, pmin_q, pmin_d, amp_q, amp_d;
    logic                  arm_hit, trig;

    assign arm_hit = ARM_EN && ({1'b0, in_sample} < ARM_TH_W);
    assign trig    = in_valid && armed_q && (in_sample >= MID_W);

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        min_d    = min_q;
        max_d    = max_q;
        mv_d     = 1'b0;
        to_d     = 1'b0;
        locked_d = locked_q;
        period_d = period_q;
        pmax_d   = pmax_q;
        pmin_d   = pmin_q;
        amp_d    = amp_q;
        if (in_valid) begin
            if (trig) begin
                armed_d = 1'b0;
                // The window being closed excludes the trigger sample itself.
                if (state_q == MEASURE) begin
                    period_d = cnt_q;
                    pmax_d   = max_q;
                    pmin_d   = min_q;
                    amp_d    = max_q - min_q;
                    mv_d     = 1'b1;
                    locked_d = 1'b1;
                end
                state_d = MEASURE;
                cnt_d   = CNT_ONE;
                min_d   = in_sample;
                max_d   = in_sample;
            end else begin
                if (arm_hit) begin
                    armed_d = 1'b1;
                end
                if (state_q == MEASURE) begin
                    if (cnt_q == CNT_MAX) begin
                        to_d     = 1'b1;
                        locked_d = 1'b0;
                        state_d  = SEEK;
                        armed_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (in_sample > max_q) max_d = in_sample;
                        if (in_sample < min_q) min_d = in_sample;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEEK;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            mv_q     <= 1'b0;
            to_q     <= 1'b0;
            locked_q <= 1'b0;
            period_q <= '0;
            pmax_q   <= '0;
            pmin_q   <= '0;
            amp_q    <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            min_q    <= min_d;
            max_q    <= max_d;
            mv_q     <= mv_d;
            to_q     <= to_d;
            locked_q <= locked_d;
            period_q <= period_d;
            pmax_q   <= pmax_d;
            pmin_q   <= pmin_d;
            amp_q    <= amp_d;
        end
    end

    assign meas_valid  = mv_q;
    assign timeout_err = to_q;
    assign locked      = locked_q;
    assign period      = period_q;
    assign peak_max    = pmax_q;
    assign peak_min    = pmin_q;
    assign amplitude   = amp_q;

endmodule

// File: tb/tb_sine_meas.sv
// Bench for sine_meas: scenario tasks drive sine, square, hold-near-midpoint and random
// streams and compare every cycle against a window-based reference model.
module tb_sine_meas;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [9:0]  in_sample;
    logic        meas_valid;
    logic [15:0] period;
    logic [9:0]  peak_max;
    logic [9:0]  peak_min;
    logic [9:0]  amplitude;
    logic        locked;
    logic        timeout_err;

    sine_meas dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sample   (in_sample),
        .meas_valid  (meas_valid),
        .period      (period),
        .peak_max    (peak_max),
        .peak_min    (peak_min),
        .amplitude   (amplitude),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [48:0] obs;
    assign obs = {meas_valid, timeout_err, locked, period, peak_max, peak_min, amplitude};

    // Reference model: a list of accepted samples since the last rising crossing.
    logic [9:0]  win[$];
    bit          m_armed;
    bit          m_seek;
    logic        e_mv, e_to, e_locked;
    logic [15:0] e_period;
    logic [9:0]  e_max, e_min, e_amp;
    logic [48:0] exp_obs;

    task automatic model(input logic r, input logic v, input logic [9:0] s);
        int mx, mn;
        e_mv = 1'b0;
        e_to = 1'b0;
        if (r) begin
            m_armed = 0; m_seek = 1; win.delete();
            e_locked = 0; e_period = 0; e_max = 0; e_min = 0; e_amp = 0;
        end else if (v) begin
            if (m_armed && s >= 10'd511) begin
                m_armed = 0;
                if (!m_seek) begin
                    mx = 0; mn = 1023;
                    foreach (win[k]) begin
                        if (int'(win[k]) > mx) mx = int'(win[k]);
                        if (int'(win[k]) < mn) mn = int'(win[k]);
                    end
                    e_period = 16'(win.size());
                    e_max = 10'(mx); e_min = 10'(mn); e_amp = 10'(mx - mn);
                    e_mv = 1; e_locked = 1;
                end
                m_seek = 0;
                win.delete();
                win.push_back(s);
            end else begin
                if (s < 10'd495) m_armed = 1;
                if (!m_seek) begin
                    if (win.size() == 65535) begin
                        e_to = 1; e_locked = 0; m_seek = 1; m_armed = 0; win.delete();
                    end else begin
                        win.push_back(s);
                    end
                end
            end
        end
        exp_obs = {e_mv, e_to, e_locked, e_period, e_max, e_min, e_amp};
    endtask

    task automatic step(input logic r, input logic v, input logic [9:0] s);
        rst = r; in_valid = v; in_sample = s;
        @(posedge clk);
        model(r, v, s);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [9:0] sine_at(input int i);
        real ph;
        ph = 2.0 * 3.14159265358979 * real'(i % 512) / 512.0;
        return 10'($rtoi(511.0 - 511.0 * $cos(ph) + 0.5));
    endfunction

    function automatic logic [9:0] square_at(input int i);
        return ((i % 100) < 50) ? 10'd0 : 10'd1000;
    endfunction

    task automatic test_reset();
        step(1, 1, 10'd1000);
        checks++;
        if (obs !== 49'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs, 49'd0);
        end
        for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
        step(1, 1, 10'($urandom_range(0, 1023)));
        checks++;
        if (obs !== 49'd0 || obs !== exp_obs) begin
            errors++; $display("FAIL reset_after_traffic got %h exp %h", obs, 49'd0);
        end
    endtask

    task automatic test_sine();
        int np = 0, last = -1, gap_err = 0;
        step(1, 0, 10'd0);
        for (int i = 0; i < 3 * 512; i++) begin
            step(0, 1, sine_at(i));
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL sine_cycle cyc %0d got %h exp %h", cyc, obs, exp_obs);
            end
            if (meas_valid) begin
                if (last >= 0 && cyc - last != 512) gap_err++;
                last = cyc; np++;
            end
        end
        checks++;
        if (np !== 2 || gap_err !== 0) begin
            errors++; $display("FAIL sine_pulses got %0d (gap errs %0d) exp 2 (0)", np, gap_err);
        end
        checks++;
        if ({period, peak_max, peak_min, amplitude, locked} !== {16'd512, 10'd1022, 10'd0, 10'd1022, 1'b1}) begin
            errors++;
            $display("FAIL sine_meas got p=%0d max=%0d min=%0d amp=%0d lk=%0b exp 512 1022 0 1022 1",
                     period, peak_max, peak_min, amplitude, locked);
        end
    endtask

    task automatic test_sine_gapped();
        int np = 0, last = -1, gap_err = 0, i = 0;
        step(1, 0, 10'd0);
        for (int c = 0; c < 2 * 3 * 512; c++) begin
            if (c % 2 == 0) begin
                step(0, 1, sine_at(i)); i++;
            end else begin
                step(0, 0, 10'($urandom_range(0, 1023)));
            end
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL gapped_cycle cyc %0d got %h exp %h", cyc, obs, exp_obs);
            end
            if (meas_valid) begin
                if (last >= 0 && cyc - last != 1024) gap_err++;
                last = cyc; np++;
            end
        end
        checks++;
        if (np !== 2 || gap_err !== 0 || period !== 16'd512) begin
            errors++;
            $display("FAIL gapped_pulses got n=%0d gaperr=%0d p=%0d exp 2 0 512", np, gap_err, period);
        end
    endtask

    task automatic test_square();
        int np = 0, i = 0;
        step(1, 0, 10'd0);
        while (i < 600) begin
            if ($urandom_range(0, 3) != 0) begin
                step(0, 1, square_at(i)); i++;
            end else begin
                step(0, 0, 10'($urandom_range(0, 1023)));
            end
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL square_cycle cyc %0d got %h exp %h", cyc, obs, exp_obs);
            end
            if (meas_valid) np++;
        end
        checks++;
        if ({period, peak_max, peak_min, amplitude} !== {16'd100, 10'd1000, 10'd0, 10'd1000} || np !== 5) begin
            errors++;
            $display("FAIL square_meas got p=%0d max=%0d min=%0d amp=%0d n=%0d exp 100 1000 0 1000 5",
                     period, peak_max, peak_min, amplitude, np);
        end
    endtask

    // Continues from the locked square wave, which ended in its high (disarmed) phase.
    task automatic test_timeout();
        int nmv = 0, nto = 0;
        for (int i = 0; i < 65600; i++) begin
            step(0, 1, (i % 2 == 0) ? 10'd505 : 10'd515);
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL timeout_cycle cyc %0d got %h exp %h", cyc, obs, exp_obs);
            end
            if (meas_valid) nmv++;
            if (timeout_err) nto++;
        end
        checks++;
        if (nto !== 1 || nmv !== 0 || locked !== 1'b0 || period !== 16'd100 || peak_max !== 10'd1000) begin
            errors++;
            $display("FAIL timeout_result got to=%0d mv=%0d lk=%0b p=%0d max=%0d exp 1 0 0 100 1000",
                     nto, nmv, locked, period, peak_max);
        end
    endtask

    task automatic test_reset_mid();
        int np = 0;
        step(1, 0, 10'd0);
        for (int i = 0; i < 428; i++) step(0, 1, sine_at(i));
        step(1, 1, sine_at(428));
        checks++;
        if (obs !== 49'd0) begin
            errors++; $display("FAIL reset_mid_clear got %h exp %h", obs, 49'd0);
        end
        for (int i = 428; i < 1165; i++) begin
            step(0, 1, sine_at(i));
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL reset_mid_cycle cyc %0d got %h exp %h", cyc, obs, exp_obs);
            end
            if (meas_valid) np++;
        end
        checks++;
        if (np !== 1 || period !== 16'd512) begin
            errors++; $display("FAIL reset_mid_pulses got n=%0d p=%0d exp 1 512", np, period);
        end
    endtask

    task automatic test_valid_gap();
        int np = 0, ntrig = 0;
        step(1, 0, 10'd0);
        for (int i = 0; i < 400; i++) begin
            step(0, 1, square_at(i));
            if (meas_valid) np++;
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL gap_cycle cyc %0d got %h exp %h", cyc, obs, exp_obs);
            end
            if (i % 100 == 50) begin
                checks++;
                if (meas_valid !== (ntrig > 0)) begin
                    errors++; $display("FAIL gap_pulse_latency cyc %0d got %0b exp %0b", cyc, meas_valid, ntrig > 0);
                end
                ntrig++;
                for (int k = 0; k < 5; k++) begin
                    step(0, 0, 10'($urandom_range(0, 1023)));
                    checks++;
                    if (meas_valid !== 1'b0 || obs !== exp_obs) begin
                        errors++; $display("FAIL gap_hold cyc %0d got %h exp %h", cyc, obs, exp_obs);
                    end
                end
            end
        end
        checks++;
        if (np !== 3 || period !== 16'd100) begin
            errors++; $display("FAIL gap_pulses got n=%0d p=%0d exp 3 100", np, period);
        end
    endtask

    task automatic test_random();
        int np = 0;
        step(1, 0, 10'd0);
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
                 10'($urandom_range(0, 1023)));
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL random_cycle cyc %0d got %h exp %h", cyc, obs, exp_obs);
            end
            if (meas_valid) np++;
        end
        checks++;
        if (np < 10) begin
            errors++; $display("FAIL random_activity got %0d pulses exp >= 10", np);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sample = '0;
        model(1, 0, 10'd0);
        @(negedge clk);
        test_reset();
        test_sine();
        test_sine_gapped();
        test_square();
        test_timeout();
        test_reset_mid();
        test_valid_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
